// File: rtl/preg_free_list_if.sv
// Rename/commit bundle for the physical register free list.
// The rename/commit side uses master; the free list uses slave.
interface preg_free_list_if #(
  parameter int PREG_NUM      = 128,
  parameter int AREG_NUM      = 32,
  parameter int MACHINE_WIDTH = 4
);
  localparam int TAG_W = $clog2(PREG_NUM);
  localparam int CNT_W = $clog2(PREG_NUM - AREG_NUM + 1);

  logic [MACHINE_WIDTH-1:0]            alloc_req;
  logic                                alloc_ok;
  logic [MACHINE_WIDTH-1:0][TAG_W-1:0] alloc_preg;
  logic [MACHINE_WIDTH-1:0]            commit_valid;
  logic [MACHINE_WIDTH-1:0]            commit_has_dst;
  logic [MACHINE_WIDTH-1:0][TAG_W-1:0] commit_old_preg;
  logic                                flush;
  logic [CNT_W-1:0]                    free_count;

  modport master (
    output alloc_req, commit_valid, commit_has_dst, commit_old_preg, flush,
    input  alloc_ok, alloc_preg, free_count
  );

  modport slave (
    input  alloc_req, commit_valid, commit_has_dst, commit_old_preg, flush,
    output alloc_ok, alloc_preg, free_count
  );
endinterface

// File: rtl/preg_free_list.sv
// Circular free list of physical register tags.
// Rename pops from head, commit pushes released tags at tail. chead tracks
// the committed pop point so that a flush can rewind head in one cycle.
module preg_free_list #(
  parameter int PREG_NUM      = 128,
  parameter int AREG_NUM      = 32,
  parameter int MACHINE_WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  preg_free_list_if.slave  bus
);
  localparam int FREE_NUM = PREG_NUM - AREG_NUM;
  localparam int MW       = MACHINE_WIDTH;
  localparam int TAG_W    = $clog2(PREG_NUM);
  localparam int PTR_W    = $clog2(FREE_NUM);
  localparam int CNT_W    = $clog2(FREE_NUM + 1);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  tag_t r_fl [FREE_NUM];
  ptr_t r_head;
  ptr_t r_chead;
  ptr_t r_tail;
  cnt_t r_free_count;

  logic [MW-1:0] w_push;
  cnt_t          w_n_a;
  cnt_t          w_n_c;
  cnt_t          w_grant_n;
  ptr_t          w_push_idx [MW];

  // Number of set bits in a slot vector.
  function automatic cnt_t f_pop(input logic [MW-1:0] v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < MW; i++) c = c + cnt_t'(v[i]);
    return c;
  endfunction

  // Modulo-FREE_NUM advance. The depth is not a power of two, so the wrap
  // subtracts the depth instead of masking. n never exceeds MW, so a
  // single subtraction is enough.
  function automatic ptr_t f_adv(input ptr_t p, input cnt_t n);
    logic [PTR_W:0] s;
    s = (PTR_W+1)'(p) + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(FREE_NUM)) s = s - (PTR_W+1)'(FREE_NUM);
    return s[PTR_W-1:0];
  endfunction

  assign w_push    = bus.commit_valid & bus.commit_has_dst;
  assign w_n_a     = f_pop(bus.alloc_req);
  assign w_n_c     = f_pop(w_push);
  // Tags freed this cycle do not count until next cycle. The grant is all-or-nothing.
  assign bus.alloc_ok   = !reset && !bus.flush && (w_n_a <= r_free_count);
  assign w_grant_n      = bus.alloc_ok ? w_n_a : '0;
  assign bus.free_count = r_free_count;

  // Per-slot compaction. Slot i reads at an offset equal to the number of
  // active lower slots, so requests 1010 take fl[head] and fl[head+1].
  for (genvar i = 0; i < MW; i++) begin : g_lane
    localparam logic [MW-1:0] LO = MW'((1 << i) - 1);
    assign bus.alloc_preg[i] = r_fl[f_adv(r_head, f_pop(bus.alloc_req & LO))];
    assign w_push_idx[i]     = f_adv(r_tail, f_pop(w_push & LO));
  end

  // Storage: after reset the list holds every non-architectural tag. Commit
  // writes each released tag at the next tail slot, in slot order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FREE_NUM; i++) r_fl[i] <= tag_t'(AREG_NUM + i);
    end else begin
      for (int i = 0; i < MW; i++)
        if (w_push[i]) r_fl[w_push_idx[i]] <= bus.commit_old_preg[i];
    end
  end

  // Pointers and count. A flush rewinds head to the post-commit chead and
  // restores the full count, because the committed state always has
  // FREE_NUM free tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head       <= '0;
      r_chead      <= '0;
      r_tail       <= '0;
      r_free_count <= cnt_t'(FREE_NUM);
    end else begin
      r_tail  <= f_adv(r_tail, w_n_c);
      r_chead <= f_adv(r_chead, w_n_c);
      if (bus.flush) begin
        r_head       <= f_adv(r_chead, w_n_c);
        r_free_count <= cnt_t'(FREE_NUM);
      end else begin
        r_head       <= f_adv(r_head, w_grant_n);
        r_free_count <= r_free_count - w_grant_n + w_n_c;
      end
    end
  end
endmodule
